lsu_rmw: RTL and testbench

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_byte_lane.sv | 53 +++++
 rtl/lsu_rmw.sv | 161 ++++++++++++++++
 tb/tb_lsu_rmw.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Holds access-size codes, the controller state type and the
// alignment/legality check used at request accept.
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int WIDX_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Misaligned or unsupported access; sub-word sizes are only legal
  // when the byte-lane datapath is built in.
  function automatic logic lsu_access_err(input logic [1:0] size,
                                          input logic [1:0] offset,
                                          input logic       subword_en);
    logic err;
    case (size)
      SZ_BYTE: err = !subword_en;
      SZ_HALF: err = !subword_en || offset[0];
      SZ_WORD: err = (offset != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational little-endian lane logic.
// Merges store data into a read word and extracts/extends load data.
// Only built into lsu_rmw when LSU_SUBWORD_EN is defined.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_merged,
  output logic [DATA_W-1:0] o_loaded
);

  logic [4:0]        w_shamt;
  logic [4:0]        w_half_lsb;
  logic [DATA_W-1:0] w_mask;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0] sb;
    sb = signed'(b);
    return sgn ? DATA_W'(sb) : {24'b0, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    sh = signed'(h);
    return sgn ? DATA_W'(sh) : {16'b0, h};
  endfunction

  // Lane select, store merge mask and load extraction.
  always_comb begin
    w_shamt    = {i_offset, 3'b000};
    w_half_lsb = {i_offset[1], 4'b0000};
    w_byte     = i_word[w_shamt +: 8];
    w_half     = i_word[w_half_lsb +: 16];
    case (i_size)
      SZ_BYTE: w_mask = 32'h0000_00FF << w_shamt;
      SZ_HALF: w_mask = 32'h0000_FFFF << w_half_lsb;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
    o_merged = (i_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);
    case (i_size)
      SZ_BYTE: o_loaded = ext_byte(w_byte, i_signed);
      SZ_HALF: o_loaded = ext_half(w_half, i_signed);
      default: o_loaded = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: single-outstanding load/store unit with read-modify-write
// for sub-word stores against a word-wide data memory.
// Macro LSU_SUBWORD_EN enables byte/half accesses; without it only
// aligned word accesses are legal and the lane datapath is not built.
module lsu_rmw
  import lsu_pkg::*;
(
  input  logic              LSU_clk,
  input  logic              LSU_rst_n,
  input  logic              LSU_req_valid,
  output logic              LSU_req_ready,
  input  logic              LSU_req_write,
  input  logic [1:0]        LSU_req_size,
  input  logic              LSU_req_signed,
  input  logic [ADDR_W-1:0] LSU_req_addr,
  input  logic [DATA_W-1:0] LSU_req_wdata,
  output logic              LSU_rsp_valid,
  input  logic              LSU_rsp_ready,
  output logic [DATA_W-1:0] LSU_rsp_rdata,
  output logic              LSU_rsp_err,
  output logic [WIDX_W-1:0] LSU_dmem_address,
  output logic [DATA_W-1:0] LSU_dmem_data_in,
  output logic              LSU_dmem_mem_write,
  output logic              LSU_dmem_mem_read,
  input  logic [DATA_W-1:0] LSU_dmem_data_out
);

`ifdef LSU_SUBWORD_EN
  localparam logic SUBWORD_EN = 1'b1;
`else
  localparam logic SUBWORD_EN = 1'b0;
`endif

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              w_accept;
  logic              w_acc_err;
  logic              r_write;
  logic              r_err;
  logic [WIDX_W-1:0] r_word_idx;
  logic [DATA_W-1:0] r_wword;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_loaded;

  assign w_accept  = LSU_req_ready && LSU_req_valid;
  assign w_acc_err = lsu_access_err(LSU_req_size, LSU_req_addr[1:0], SUBWORD_EN);

  // State register; async reset also kills an in-flight WRITE strobe.
  always_ff @(posedge LSU_clk or negedge LSU_rst_n) begin
    if (!LSU_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state: errors respond at once, word stores skip the read.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_acc_err)                                    w_state_nxt = RESP;
          else if (LSU_req_write && LSU_req_size == SZ_WORD) w_state_nxt = WRITE;
          else                                              w_state_nxt = READ;
        end
      end
      READ:    w_state_nxt = r_write ? WRITE : RESP;
      WRITE:   w_state_nxt = RESP;
      RESP:    w_state_nxt = LSU_rsp_ready ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; everything idles at zero.
  always_comb begin
    LSU_req_ready      = 1'b0;
    LSU_rsp_valid      = 1'b0;
    LSU_rsp_rdata      = '0;
    LSU_rsp_err        = 1'b0;
    LSU_dmem_address   = '0;
    LSU_dmem_data_in   = '0;
    LSU_dmem_mem_write = 1'b0;
    LSU_dmem_mem_read  = 1'b0;
    case (r_state)
      IDLE: LSU_req_ready = LSU_rst_n;
      READ: begin
        LSU_dmem_mem_read = 1'b1;
        LSU_dmem_address  = r_word_idx;
      end
      WRITE: begin
        LSU_dmem_mem_write = 1'b1;
        LSU_dmem_address   = r_word_idx;
        LSU_dmem_data_in   = r_wword;
      end
      RESP: begin
        LSU_rsp_valid = 1'b1;
        LSU_rsp_rdata = r_rdata;
        LSU_rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  // Control fields of the request, latched on accept.
  always_ff @(posedge LSU_clk or negedge LSU_rst_n) begin
    if (!LSU_rst_n) begin
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_write <= LSU_req_write;
      r_err   <= w_acc_err;
    end
  end

  // Data path: latch address/store word on accept, then capture the
  // merged store word or the extracted load value at the end of READ.
  always_ff @(posedge LSU_clk) begin
    if (w_accept) begin
      r_word_idx <= LSU_req_addr[ADDR_W-1:2];
      r_wword    <= LSU_req_wdata;
      r_rdata    <= '0;
    end else if (r_state == READ) begin
      if (r_write) r_wword <= w_merged;
      else         r_rdata <= w_loaded;
    end
  end

`ifdef LSU_SUBWORD_EN
  logic [1:0] r_size;
  logic [1:0] r_offset;
  logic       r_signed;

  // Lane-select fields, latched on accept.
  always_ff @(posedge LSU_clk or negedge LSU_rst_n) begin
    if (!LSU_rst_n) begin
      r_size   <= SZ_WORD;
      r_offset <= 2'b00;
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_size   <= LSU_req_size;
      r_offset <= LSU_req_addr[1:0];
      r_signed <= LSU_req_signed;
    end
  end

  lsu_byte_lane u_lane (
    .i_word   (LSU_dmem_data_out),
    .i_wdata  (r_wword),
    .i_offset (r_offset),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_merged (w_merged),
    .o_loaded (w_loaded)
  );
`else
  logic w_unused;
  assign w_unused = ^{LSU_req_signed};
  assign w_merged = r_wword;
  assign w_loaded = LSU_dmem_data_out;
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed self-checking bench for lsu_rmw with a
// word-wide memory model. Expectations follow LSU_SUBWORD_EN.
module tb_lsu_rmw;
  import lsu_pkg::*;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBW = 1'b1;
`else
  localparam bit SUBW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  dmem_address;
  logic [31:0] dmem_data_in, dmem_data_out;
  logic        dmem_mem_write, dmem_mem_read;

  logic [31:0] mem [256];
  logic        tb_we;
  logic [7:0]  tb_wa;
  logic [31:0] tb_wd;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct packed {
    logic        issub;
    logic [1:0]  sz;
    logic        sgn;
    logic [9:0]  addr;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vecs [7];

  lsu_rmw dut (
    .LSU_clk            (clk),
    .LSU_rst_n          (rst_n),
    .LSU_req_valid      (req_valid),
    .LSU_req_ready      (req_ready),
    .LSU_req_write      (req_write),
    .LSU_req_size       (req_size),
    .LSU_req_signed     (req_signed),
    .LSU_req_addr       (req_addr),
    .LSU_req_wdata      (req_wdata),
    .LSU_rsp_valid      (rsp_valid),
    .LSU_rsp_ready      (rsp_ready),
    .LSU_rsp_rdata      (rsp_rdata),
    .LSU_rsp_err        (rsp_err),
    .LSU_dmem_address   (dmem_address),
    .LSU_dmem_data_in   (dmem_data_in),
    .LSU_dmem_mem_write (dmem_mem_write),
    .LSU_dmem_mem_read  (dmem_mem_read),
    .LSU_dmem_data_out  (dmem_data_out)
  );

  always #5 clk = ~clk;

  assign dmem_data_out = mem[dmem_address];

  always @(posedge clk) begin
    if (dmem_mem_write) begin
      mem[dmem_address] <= dmem_data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (dmem_mem_read) rd_cnt <= rd_cnt + 1;
    if (dmem_mem_write && dmem_mem_read) both_cnt <= both_cnt + 1;
    if (tb_we) mem[tb_wa] <= tb_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [9:0] addr, input logic [31:0] wd, input int hold,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int wr_d, output int rd_d);
    int wr0, rd0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_size   = ~sz;
    req_signed = ~sgn;
    req_addr   = 10'h3FF;
    req_wdata  = 32'h5A5A_A5A5;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, rdata);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
    wr_d = wr_cnt - wr0;
    rd_d = rd_cnt - rd0;
  endtask

  initial begin
    int          lat, wr_d, rd_d, wr0, k;
    logic [31:0] rd;
    logic        er;
    logic [31:0] m4;

    ld_vecs[0] = '{1'b1, SZ_BYTE, 1'b1, 10'h011, 32'hFFFF_FFFF};
    ld_vecs[1] = '{1'b1, SZ_HALF, 1'b0, 10'h012, 32'h0000_8000};
    ld_vecs[2] = '{1'b1, SZ_HALF, 1'b1, 10'h012, 32'hFFFF_8000};
    ld_vecs[3] = '{1'b1, SZ_BYTE, 1'b0, 10'h011, 32'h0000_00FF};
    ld_vecs[4] = '{1'b1, SZ_BYTE, 1'b1, 10'h010, 32'h0000_007F};
    ld_vecs[5] = '{1'b1, SZ_BYTE, 1'b1, 10'h013, 32'hFFFF_FF80};
    ld_vecs[6] = '{1'b0, SZ_WORD, 1'b1, 10'h010, 32'h8000_FF7F};

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mem_write", {31'b0, dmem_mem_write}, 32'd0);
    chk("rst_mem_read",  {31'b0, dmem_mem_read}, 32'd0);
    chk("rst_address",   {24'b0, dmem_address}, 32'd0);
    chk("rst_data_in",   dmem_data_in, 32'd0);
    chk("rst_rdata",     rsp_rdata, 32'd0);
    chk("rst_err",       {31'b0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);

    // Word store then word load
    run_req(1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEAD_BEEF, 0, lat, rd, er, wr_d, rd_d);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_err", {31'b0, er}, 32'd0);
    chk("wst_rdata", rd, 32'd0);
    chk("wst_wr_pulses", 32'(wr_d), 32'd1);
    chk("wst_rd_pulses", 32'(rd_d), 32'd0);
    chk("wst_mem", mem[4], 32'hDEAD_BEEF);
    run_req(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 0, lat, rd, er, wr_d, rd_d);
    chk("wld_lat", 32'(lat), 32'd2);
    chk("wld_rdata", rd, 32'hDEAD_BEEF);
    chk("wld_err", {31'b0, er}, 32'd0);
    chk("wld_rd_pulses", 32'(rd_d), 32'd1);

    // Byte store read-modify-write
    preload(8'd4, 32'h1122_3344);
    run_req(1'b1, SZ_BYTE, 1'b0, 10'h012, 32'hFFFF_FFAA, 0, lat, rd, er, wr_d, rd_d);
    chk("bst_lat", 32'(lat), SUBW ? 32'd3 : 32'd1);
    chk("bst_err", {31'b0, er}, SUBW ? 32'd0 : 32'd1);
    chk("bst_mem", mem[4], SUBW ? 32'h11AA_3344 : 32'h1122_3344);
    chk("bst_wr_pulses", 32'(wr_d), SUBW ? 32'd1 : 32'd0);
    chk("bst_rd_pulses", 32'(rd_d), SUBW ? 32'd1 : 32'd0);

    // Sub-word and word loads with extension
    preload(8'd4, 32'h8000_FF7F);
    for (int i = 0; i < 7; i++) begin
      run_req(1'b0, ld_vecs[i].sz, ld_vecs[i].sgn, ld_vecs[i].addr, 32'h0, 0, lat, rd, er, wr_d, rd_d);
      if (ld_vecs[i].issub && !SUBW) begin
        chk($sformatf("ld%0d_rdata", i), rd, 32'd0);
        chk($sformatf("ld%0d_err", i), {31'b0, er}, 32'd1);
        chk($sformatf("ld%0d_lat", i), 32'(lat), 32'd1);
      end else begin
        chk($sformatf("ld%0d_rdata", i), rd, ld_vecs[i].exp);
        chk($sformatf("ld%0d_err", i), {31'b0, er}, 32'd0);
        chk($sformatf("ld%0d_lat", i), 32'(lat), 32'd2);
      end
    end

    // Half store into upper half
    run_req(1'b1, SZ_HALF, 1'b0, 10'h012, 32'h1234_BEEF, 0, lat, rd, er, wr_d, rd_d);
    chk("hst_lat", 32'(lat), SUBW ? 32'd3 : 32'd1);
    chk("hst_mem", mem[4], SUBW ? 32'hBEEF_FF7F : 32'h8000_FF7F);
    m4 = mem[4];

    // Misaligned / illegal accesses
    run_req(1'b0, SZ_HALF, 1'b1, 10'h013, 32'h0, 0, lat, rd, er, wr_d, rd_d);
    chk("e_hld_err", {31'b0, er}, 32'd1);
    chk("e_hld_rdata", rd, 32'd0);
    chk("e_hld_lat", 32'(lat), 32'd1);
    chk("e_hld_strobes", 32'(wr_d + rd_d), 32'd0);
    run_req(1'b1, SZ_WORD, 1'b0, 10'h012, 32'hCAFE_0001, 0, lat, rd, er, wr_d, rd_d);
    chk("e_wst_err", {31'b0, er}, 32'd1);
    chk("e_wst_rdata", rd, 32'd0);
    chk("e_wst_lat", 32'(lat), 32'd1);
    chk("e_wst_strobes", 32'(wr_d + rd_d), 32'd0);
    chk("e_wst_mem", mem[4], m4);
    run_req(1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 0, lat, rd, er, wr_d, rd_d);
    chk("e_sz3_err", {31'b0, er}, 32'd1);
    chk("e_sz3_lat", 32'(lat), 32'd1);
    chk("e_sz3_strobes", 32'(wr_d + rd_d), 32'd0);

    // Backpressure on the response
    run_req(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, 5, lat, rd, er, wr_d, rd_d);
    chk("bp_rdata", rd, m4);
    chk("bp_lat", 32'(lat), 32'd2);
    @(negedge clk);
    chk("bp_idle", {31'b0, req_ready}, 32'd1);

    // Reset during the WRITE cycle of a store
    preload(8'd5, 32'h1234_5678);
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = SUBW ? SZ_BYTE : SZ_WORD;
    req_signed = 1'b0;
    req_addr   = 10'h014;
    req_wdata  = SUBW ? 32'h0000_005A : 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!dmem_mem_write && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("rw_mem_write", {31'b0, dmem_mem_write}, 32'd1);
    chk("rw_address", {24'b0, dmem_address}, 32'd5);
    chk("rw_data_in", dmem_data_in, SUBW ? 32'h1234_565A : 32'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    chk("rw_write_drop", {31'b0, dmem_mem_write}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_ready", {31'b0, req_ready}, 32'd1);
    chk("rw_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rw_mem", mem[5], 32'h1234_5678);
    chk("rw_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Unit still operational afterwards
    run_req(1'b0, SZ_WORD, 1'b0, 10'h014, 32'h0, 0, lat, rd, er, wr_d, rd_d);
    chk("post_ld_rdata", rd, 32'h1234_5678);
    chk("post_ld_err", {31'b0, er}, 32'd0);
    chk("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
